// File: rtl/npc_pkg.sv
// Shared definitions for the NPC sequencer: FSM state encoding, fixed
// instruction encodings and datapath widths.
package npc_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned WDT_W = 8;

  localparam logic [XLEN-1:0] INST_NOP         = 32'h0000_0013;
  localparam logic [XLEN-1:0] INST_EBREAK      = 32'h0010_0073;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h8000_0000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    EXEC  = 3'd3,
    HALT  = 3'd4,
    ERR   = 3'd5
  } state_e;

  // True when the latched instruction is the halt request.
  function automatic logic is_ebreak(input logic [XLEN-1:0] i);
    return i == INST_EBREAK;
  endfunction

endpackage

// File: rtl/npc_fetch_wdt.sv
// Fetch watchdog: clearable, incrementing counter with a terminal-count flag.
//   clk, rst : clock and async active-low reset
//   clr      : synchronous clear (takes priority over inc)
//   inc      : count up by one
//   tc_c     : combinational, high while count equals TERM
module npc_fetch_wdt
  import npc_pkg::*;
#(
  parameter int unsigned W    = WDT_W,
  parameter int unsigned TERM = 254
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc_c
);

  logic [W-1:0] count;

  // Counter register; clear wins so a new fetch always starts from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

  assign tc_c = (count == W'(TERM));

endmodule

// File: rtl/npc_seq_ctrl.sv
// Multi-cycle sequencer for the NPC core: owns the PC, fetches over a
// valid/ready request + valid-only response channel, latches the instruction
// for the decoder, strobes register writeback once per retired instruction,
// and flags ebreak halt or fetch timeout.
//   clk, rst                   : clock, async active-low reset
//   run                        : allow starting a new instruction from IDLE/EXEC
//   imem_req_valid/ready, addr : fetch request channel (addr tracks pc)
//   imem_rsp_valid/data        : fetch response (single-cycle pulse)
//   inst                       : latched instruction to the decoder
//   pc / next_pc               : current PC / successor from the datapath
//   reg_wen                    : register-file write strobe
//   halted, err                : sticky ebreak / timeout flags
//   instret                    : retired-instruction count (wraps)
module npc_seq_ctrl
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_rsp_valid,
  input  logic [XLEN-1:0]  imem_rsp_data,
  output logic [XLEN-1:0]  inst,
  output logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  next_pc,
  output logic             reg_wen,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] instret
);

  state_e state_q, state_d;

  logic             req_fire;
  logic             wd_clr;
  logic             wd_inc;
  logic             wd_tc;
  logic [XLEN-1:0]  pc_d;
  logic [XLEN-1:0]  inst_d;
  logic [CNT_W-1:0] instret_d;
  logic             req_valid_d;
  logic             reg_wen_d;
  logic             halted_d;
  logic             err_d;

  // Request handshake only counts while actually presenting a fetch.
  assign req_fire  = (state_q == FETCH) && imem_req_ready;
  assign imem_addr = pc;

  // Watchdog counts cycles spent waiting for the response; terminal count is
  // TIMEOUT-1 so the error fires on the TIMEOUT-th WAIT cycle.
  npc_fetch_wdt #(
    .W    (WDT_W),
    .TERM (TIMEOUT - 1)
  ) u_wdt (
    .clk  (clk),
    .rst  (rst),
    .clr  (wd_clr),
    .inc  (wd_inc),
    .tc_c (wd_tc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (run) state_d = FETCH;
      FETCH: if (req_fire) state_d = WAIT;
      WAIT: begin
        // A response in the terminal cycle still wins over the timeout.
        if (imem_rsp_valid)  state_d = EXEC;
        else if (wd_tc)      state_d = ERR;
      end
      EXEC: begin
        if (is_ebreak(inst)) state_d = HALT;
        else if (run)        state_d = FETCH;
        else                 state_d = IDLE;
      end
      HALT:    state_d = HALT;
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath-update logic; flag outputs are computed from the
  // next state so their registers line up with the state they describe.
  always_comb begin
    pc_d      = pc;
    inst_d    = inst;
    instret_d = instret;
    wd_clr    = 1'b0;
    wd_inc    = 1'b0;
    case (state_q)
      FETCH: wd_clr = req_fire;
      WAIT: begin
        wd_inc = 1'b1;
        if (imem_rsp_valid) inst_d = imem_rsp_data;
      end
      EXEC: begin
        instret_d = instret + CNT_W'(1);
        if (!is_ebreak(inst)) pc_d = next_pc;
      end
      default: ;
    endcase
    req_valid_d = (state_d == FETCH);
    reg_wen_d   = (state_d == EXEC) && !is_ebreak(inst_d);
    halted_d    = (state_d == HALT);
    err_d       = (state_d == ERR);
  end

  // Registered outputs and architectural state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc             <= RESET_PC;
      inst           <= INST_NOP;
      instret        <= '0;
      imem_req_valid <= 1'b0;
      reg_wen        <= 1'b0;
      halted         <= 1'b0;
      err            <= 1'b0;
    end else begin
      pc             <= pc_d;
      inst           <= inst_d;
      instret        <= instret_d;
      imem_req_valid <= req_valid_d;
      reg_wen        <= reg_wen_d;
      halted         <= halted_d;
      err            <= err_d;
    end
  end

endmodule

// File: tb/tb_npc_seq_ctrl.sv
// Directed, self-checking bench for npc_seq_ctrl (TIMEOUT=4 instance).
module tb_npc_seq_ctrl;

  localparam logic [31:0] RPC    = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ADDI   = 32'h0010_0093;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        reg_wen;
  logic        halted;
  logic        err;
  logic [31:0] instret;

  int checks = 0;
  int errors = 0;
  int accept_cnt = 0;

  always #5 clk = ~clk;

  // Datapath stand-in: sequential successor.
  assign next_pc = pc + 32'd4;

  always @(posedge clk) begin
    if (imem_req_valid && imem_req_ready) accept_cnt <= accept_cnt + 1;
  end

  npc_seq_ctrl #(
    .RESET_PC (32'h8000_0000),
    .TIMEOUT  (4),
    .CNT_W    (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .run            (run),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst           (inst),
    .pc             (pc),
    .next_pc        (next_pc),
    .reg_wen        (reg_wen),
    .halted         (halted),
    .err            (err),
    .instret        (instret)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    run = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    tick();
    tick();
    rst = 1'b1;
    accept_cnt = 0;
  endtask

  task automatic test_reset;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid cyc%0d: got %b expected 0", i, imem_req_valid); end
      checks++;
      if (pc !== RPC) begin errors++; $display("FAIL reset_pc cyc%0d: got %h expected %h", i, pc, RPC); end
      checks++;
      if (inst !== NOP) begin errors++; $display("FAIL reset_inst cyc%0d: got %h expected %h", i, inst, NOP); end
      tick();
    end
    checks++;
    if ({reg_wen, halted, err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {reg_wen, halted, err}); end
    checks++;
    if (instret !== 32'd0) begin errors++; $display("FAIL reset_instret: got %0d expected 0", instret); end
  endtask

  task automatic test_straight_line;
    logic [31:0] exp_pc;
    do_reset();
    run = 1'b1;
    imem_req_ready = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      exp_pc = RPC + 32'(4 * k);
      checks++;
      if (imem_req_valid !== 1'b1 || imem_addr !== exp_pc) begin errors++; $display("FAIL sl_fetch%0d: got valid=%b addr=%h expected valid=1 addr=%h", k, imem_req_valid, imem_addr, exp_pc); end
      tick();
      checks++;
      if (imem_req_valid !== 1'b0 || reg_wen !== 1'b0) begin errors++; $display("FAIL sl_wait%0d: got valid=%b wen=%b expected 0 0", k, imem_req_valid, reg_wen); end
      imem_rsp_valid = 1'b1;
      imem_rsp_data = ADDI;
      tick();
      imem_rsp_valid = 1'b0;
      checks++;
      if (reg_wen !== 1'b1 || inst !== ADDI || pc !== exp_pc) begin errors++; $display("FAIL sl_exec%0d: got wen=%b inst=%h pc=%h expected 1 %h %h", k, reg_wen, inst, pc, ADDI, exp_pc); end
      tick();
      checks++;
      if (reg_wen !== 1'b0 || pc !== exp_pc + 32'd4) begin errors++; $display("FAIL sl_next%0d: got wen=%b pc=%h expected 0 %h", k, reg_wen, pc, exp_pc + 32'd4); end
    end
    checks++;
    if (instret !== 32'd3) begin errors++; $display("FAIL sl_instret: got %0d expected 3", instret); end
    checks++;
    if (pc !== 32'h8000_000C) begin errors++; $display("FAIL sl_pc_final: got %h expected 8000000c", pc); end
  endtask

  task automatic test_backpressure;
    do_reset();
    run = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (imem_req_valid !== 1'b1 || imem_addr !== RPC || reg_wen !== 1'b0) begin errors++; $display("FAIL bp_stall%0d: got valid=%b addr=%h wen=%b expected 1 %h 0", i, imem_req_valid, imem_addr, reg_wen, RPC); end
      tick();
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    checks++;
    if (imem_req_valid !== 1'b0 || reg_wen !== 1'b0) begin errors++; $display("FAIL bp_wait1: got valid=%b wen=%b expected 0 0", imem_req_valid, reg_wen); end
    tick();
    checks++;
    if (reg_wen !== 1'b0) begin errors++; $display("FAIL bp_wait2: got wen=%b expected 0", reg_wen); end
    imem_rsp_valid = 1'b1;
    imem_rsp_data = ADDI;
    tick();
    imem_rsp_valid = 1'b0;
    run = 1'b0;
    checks++;
    if (reg_wen !== 1'b1) begin errors++; $display("FAIL bp_exec: got wen=%b expected 1", reg_wen); end
    tick();
    checks++;
    if (pc !== 32'h8000_0004 || imem_req_valid !== 1'b0 || reg_wen !== 1'b0) begin errors++; $display("FAIL bp_park: got pc=%h valid=%b wen=%b expected 80000004 0 0", pc, imem_req_valid, reg_wen); end
    checks++;
    if (accept_cnt !== 1) begin errors++; $display("FAIL bp_accepts: got %0d expected 1", accept_cnt); end
  endtask

  task automatic test_ebreak;
    do_reset();
    run = 1'b1;
    imem_req_ready = 1'b1;
    tick();
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = EBREAK;
    tick();
    imem_rsp_valid = 1'b0;
    checks++;
    if (reg_wen !== 1'b0 || inst !== EBREAK || halted !== 1'b0) begin errors++; $display("FAIL eb_exec: got wen=%b inst=%h halted=%b expected 0 %h 0", reg_wen, inst, halted, EBREAK); end
    tick();
    checks++;
    if (halted !== 1'b1 || pc !== RPC || instret !== 32'd1) begin errors++; $display("FAIL eb_halt: got halted=%b pc=%h instret=%0d expected 1 %h 1", halted, pc, instret, RPC); end
    imem_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (imem_req_valid !== 1'b0 || halted !== 1'b1 || reg_wen !== 1'b0 || accept_cnt !== 1) begin errors++; $display("FAIL eb_sticky: got valid=%b halted=%b wen=%b accepts=%0d expected 0 1 0 1", imem_req_valid, halted, reg_wen, accept_cnt); end
  endtask

  task automatic test_timeout;
    do_reset();
    run = 1'b1;
    imem_req_ready = 1'b1;
    tick();
    tick();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL to_before: got err=%b expected 0", err); end
    tick();
    checks++;
    if (err !== 1'b1 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL to_err: got err=%b valid=%b expected 1 0", err, imem_req_valid); end
    imem_rsp_valid = 1'b1;
    imem_rsp_data = ADDI;
    tick();
    imem_rsp_valid = 1'b0;
    tick();
    checks++;
    if (err !== 1'b1 || reg_wen !== 1'b0 || instret !== 32'd0) begin errors++; $display("FAIL to_sticky: got err=%b wen=%b instret=%0d expected 1 0 0", err, reg_wen, instret); end
  endtask

  task automatic test_timeout_rsp;
    do_reset();
    run = 1'b1;
    imem_req_ready = 1'b1;
    tick();
    tick();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data = ADDI;
    tick();
    imem_rsp_valid = 1'b0;
    run = 1'b0;
    checks++;
    if (err !== 1'b0 || reg_wen !== 1'b1 || inst !== ADDI) begin errors++; $display("FAIL tr_exec: got err=%b wen=%b inst=%h expected 0 1 %h", err, reg_wen, inst, ADDI); end
    tick();
    checks++;
    if (err !== 1'b0 || instret !== 32'd1 || pc !== 32'h8000_0004) begin errors++; $display("FAIL tr_after: got err=%b instret=%0d pc=%h expected 0 1 80000004", err, instret, pc); end
  endtask

  task automatic test_async_reset;
    do_reset();
    run = 1'b1;
    imem_req_ready = 1'b1;
    tick();
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data = ADDI;
    tick();
    imem_rsp_valid = 1'b0;
    tick();
    tick();
    imem_req_ready = 1'b0;
    tick();
    checks++;
    if (pc !== 32'h8000_0004 || instret !== 32'd1) begin errors++; $display("FAIL ar_pre: got pc=%h instret=%0d expected 80000004 1", pc, instret); end
    rst = 1'b0;
    #2;
    checks++;
    if (pc !== RPC || inst !== NOP || instret !== 32'd0 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL ar_immediate: got pc=%h inst=%h instret=%0d valid=%b expected %h %h 0 0", pc, inst, instret, imem_req_valid, RPC, NOP); end
    run = 1'b0;
    tick();
    rst = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = ADDI;
    tick();
    checks++;
    if (inst !== NOP || reg_wen !== 1'b0 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL ar_stale_idle: got inst=%h wen=%b valid=%b expected %h 0 0", inst, reg_wen, imem_req_valid, NOP); end
    run = 1'b1;
    tick();
    tick();
    checks++;
    if (inst !== NOP || reg_wen !== 1'b0 || imem_req_valid !== 1'b1) begin errors++; $display("FAIL ar_stale_fetch: got inst=%h wen=%b valid=%b expected %h 0 1", inst, reg_wen, imem_req_valid, NOP); end
    imem_rsp_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    run = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    test_reset();
    test_straight_line();
    test_backpressure();
    test_ebreak();
    test_timeout();
    test_timeout_rsp();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
